// File: rtl/data_path.sv
// Bus-based 32-bit CPU execution core: register file, special registers, shared
// bus mux and combinational ALU, all sequenced cycle by cycle by the control unit.
module data_path (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
  input  logic        HIout, LOout, PCout, Zhighout, Zlowout, MDRout,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MARq,
  output logic [31:0] IRq
);

  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
  logic [63:0] z_q;
  logic [31:0] mdr_d;
  logic [63:0] z_d;

  logic [15:0] r_out, r_in;
  logic [12:0] op;
  logic [31:0] bus;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  // Bit 0 is the first op in port order and therefore the highest priority.
  assign op    = {NOT, NEG, DIV, MUL, OR, AND, ROL, ROR, SHL, SHRA, SHR, SUB, ADD};

  // Lowest-numbered general register wins, then HI, LO, Zhigh, Zlow, PC, MDR.
  always_comb begin
    bus = '0;
    if (|r_out) begin
      for (int i = 15; i >= 0; i--) begin
        if (r_out[i]) bus = r_q[i];
      end
    end else if (HIout)    bus = hi_q;
    else if (LOout)        bus = lo_q;
    else if (Zhighout)     bus = z_q[63:32];
    else if (Zlowout)      bus = z_q[31:0];
    else if (PCout)        bus = pc_q;
    else if (MDRout)       bus = mdr_q;
  end

  assign BusMuxOut = bus;
  assign MARq      = mar_q;
  assign IRq       = ir_q;

  logic [4:0]         shamt;
  logic [31:0]        shra_v, ror_v, rol_v;
  logic signed [63:0] a_ext, b_ext, prod;
  logic signed [31:0] a_s, b_s, quo, rem;

  assign shamt  = bus[4:0];
  assign shra_v = $signed(y_q) >>> shamt;
  assign ror_v  = (y_q >> shamt) | (y_q << (6'd32 - {1'b0, shamt}));
  assign rol_v  = (y_q << shamt) | (y_q >> (6'd32 - {1'b0, shamt}));
  assign a_ext  = {{32{y_q[31]}}, y_q};
  assign b_ext  = {{32{bus[31]}}, bus};
  assign prod   = a_ext * b_ext;
  assign a_s    = y_q;
  assign b_s    = bus;

  // Divide-by-zero and the single overflowing quotient get fixed results.
  always_comb begin
    quo = '0;
    rem = a_s;
    if (b_s == 32'sd0) begin
      quo = '0;
      rem = a_s;
    end else if (a_s == 32'sh8000_0000 && b_s == -32'sd1) begin
      quo = a_s;
      rem = '0;
    end else begin
      quo = a_s / b_s;
      rem = a_s % b_s;
    end
  end

  always_comb begin
    z_d = {32'h0, bus + 32'd1};
    if      (op[0])  z_d = {32'h0, y_q + bus};
    else if (op[1])  z_d = {32'h0, y_q - bus};
    else if (op[2])  z_d = {32'h0, y_q >> shamt};
    else if (op[3])  z_d = {32'h0, shra_v};
    else if (op[4])  z_d = {32'h0, y_q << shamt};
    else if (op[5])  z_d = {32'h0, ror_v};
    else if (op[6])  z_d = {32'h0, rol_v};
    else if (op[7])  z_d = {32'h0, y_q & bus};
    else if (op[8])  z_d = {32'h0, y_q | bus};
    else if (op[9])  z_d = prod;
    else if (op[10]) z_d = {rem, quo};
    else if (op[11]) z_d = {32'h0, 32'd0 - bus};
    else if (op[12]) z_d = {32'h0, ~bus};
  end

  assign mdr_d = Read ? Mdatain : bus;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= bus;
      end
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (Yin)   y_q   <= bus;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= mdr_d;
      if (Zin)   z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed and randomized checks of data_path: reset, bus priority, transfers,
// fetch sequence and every ALU operation against an integer-level ALU model.
module tb_data_path;

  logic        Clock, Clear;
  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin;
  logic        HIout, LOout, PCout, Zhighout, Zlowout, MDRout, Read;
  logic [31:0] Mdatain;
  logic [15:0] r_out_v, r_in_v;
  logic [12:0] op_v;
  logic [31:0] BusMuxOut, MARq, IRq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  data_path dut (
    .Clock(Clock), .Clear(Clear),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin),
    .HIout(HIout), .LOout(LOout), .PCout(PCout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .MDRout(MDRout), .Read(Read), .Mdatain(Mdatain),
    .R0out(r_out_v[0]), .R1out(r_out_v[1]), .R2out(r_out_v[2]), .R3out(r_out_v[3]),
    .R4out(r_out_v[4]), .R5out(r_out_v[5]), .R6out(r_out_v[6]), .R7out(r_out_v[7]),
    .R8out(r_out_v[8]), .R9out(r_out_v[9]), .R10out(r_out_v[10]), .R11out(r_out_v[11]),
    .R12out(r_out_v[12]), .R13out(r_out_v[13]), .R14out(r_out_v[14]), .R15out(r_out_v[15]),
    .R0in(r_in_v[0]), .R1in(r_in_v[1]), .R2in(r_in_v[2]), .R3in(r_in_v[3]),
    .R4in(r_in_v[4]), .R5in(r_in_v[5]), .R6in(r_in_v[6]), .R7in(r_in_v[7]),
    .R8in(r_in_v[8]), .R9in(r_in_v[9]), .R10in(r_in_v[10]), .R11in(r_in_v[11]),
    .R12in(r_in_v[12]), .R13in(r_in_v[13]), .R14in(r_in_v[14]), .R15in(r_in_v[15]),
    .ADD(op_v[0]), .SUB(op_v[1]), .SHR(op_v[2]), .SHRA(op_v[3]), .SHL(op_v[4]),
    .ROR(op_v[5]), .ROL(op_v[6]), .AND(op_v[7]), .OR(op_v[8]), .MUL(op_v[9]),
    .DIV(op_v[10]), .NEG(op_v[11]), .NOT(op_v[12]),
    .BusMuxOut(BusMuxOut), .MARq(MARq), .IRq(IRq)
  );

  // Clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference ALU: signed integer arithmetic and bit-at-a-time shifting.
  function automatic logic [63:0] ref_alu(int k, logic [31:0] a, logic [31:0] b);
    int          sa, sb, s;
    longint      p;
    logic [31:0] t;
    sa = a;
    sb = b;
    s  = int'(b[4:0]);
    t  = a;
    case (k)
      0:  return {32'h0, a + b};
      1:  return {32'h0, a - b};
      2:  begin repeat (s) t = t / 2; return {32'h0, t}; end
      3:  begin repeat (s) t = {t[31], t[31:1]}; return {32'h0, t}; end
      4:  begin repeat (s) t = t * 2; return {32'h0, t}; end
      5:  begin repeat (s) t = {t[0], t[31:1]}; return {32'h0, t}; end
      6:  begin repeat (s) t = {t[30:0], t[31]}; return {32'h0, t}; end
      7:  return {32'h0, a & b};
      8:  return {32'h0, a | b};
      9:  begin p = longint'(sa) * longint'(sb); return p; end
      10: begin
            if (sb == 0) return {a, 32'h0};
            if (a == 32'h8000_0000 && sb == -1) return {32'h0, a};
            return {32'(sa % sb), 32'(sa / sb)};
          end
      11: return {32'h0, 32'd0 - b};
      12: return {32'h0, ~b};
      default: return {32'h0, b + 32'd1};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic ctrl_clear();
    {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin} = '0;
    {HIout, LOout, PCout, Zhighout, Zlowout, MDRout, Read} = '0;
    r_out_v = '0;
    r_in_v  = '0;
    op_v    = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
    ctrl_clear();
  endtask

  task automatic load_mem(int n, logic [31:0] val);
    Mdatain = val; Read = 1'b1; MDRin = 1'b1;
    step();
    MDRout = 1'b1; r_in_v[n] = 1'b1;
    step();
  endtask

  task automatic read_reg(int n, output logic [31:0] v);
    r_out_v[n] = 1'b1;
    #1 v = BusMuxOut;
    step();
  endtask

  task automatic read_z(output logic [31:0] lo, output logic [31:0] hi);
    Zlowout = 1'b1;
    #1 lo = BusMuxOut;
    Zlowout = 1'b0; Zhighout = 1'b1;
    #1 hi = BusMuxOut;
    step();
  endtask

  // Loads A into Y (via R4) and B into R5, runs the ALU with mask ops, checks Z.
  task automatic do_alu(string tag, logic [12:0] ops, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp);
    logic [31:0] lo, hi;
    load_mem(4, a);
    load_mem(5, b);
    r_out_v[4] = 1'b1; Yin = 1'b1;
    step();
    r_out_v[5] = 1'b1; op_v = ops; Zin = 1'b1;
    step();
    exp_q.push_back(exp[31:0]);
    exp_q.push_back(exp[63:32]);
    read_z(lo, hi);
    check({tag, " zlow"}, lo, exp_q.pop_front());
    check({tag, " zhigh"}, hi, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] v, lo, hi, a, b;
    int          k;
    logic [12:0] m;

    ctrl_clear();
    Mdatain = '0;
    Clear   = 1'b0;
    #12;
    check("reset bus", BusMuxOut, 32'h0);
    check("reset mar", MARq, 32'h0);
    check("reset ir", IRq, 32'h0);
    Clear = 1'b1;
    @(negedge Clock);

    // Fetch T0..T2
    PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
    step();
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h0886_0000;
    step();
    MDRout = 1'b1; IRin = 1'b1;
    step();
    check("fetch mar", MARq, 32'h0);
    check("fetch ir", IRq, 32'h0886_0000);
    PCout = 1'b1;
    #1 check("fetch pc", BusMuxOut, 32'h1);
    step();

    // SUB through Y and Z into R1
    load_mem(2, 32'h25);
    load_mem(3, 32'h14);
    r_out_v[2] = 1'b1; Yin = 1'b1;
    step();
    r_out_v[3] = 1'b1; op_v[1] = 1'b1; Zin = 1'b1;
    step();
    Zlowout = 1'b1; r_in_v[1] = 1'b1;
    step();
    read_reg(1, v);
    check("sub r1", v, 32'h11);
    read_z(lo, hi);
    check("sub zhigh", hi, 32'h0);

    // MAR, HI/LO, bus priority, fan-out load
    r_out_v[2] = 1'b1; MARin = 1'b1;
    step();
    check("mar load", MARq, 32'h25);
    r_out_v[2] = 1'b1; HIin = 1'b1;
    step();
    r_out_v[3] = 1'b1; LOin = 1'b1;
    step();
    r_out_v[3] = 1'b1; PCout = 1'b1; HIout = 1'b1;
    #1 check("prio r3 over hi/pc", BusMuxOut, 32'h14);
    r_out_v[3] = 1'b0;
    #1 check("prio hi over pc", BusMuxOut, 32'h25);
    HIout = 1'b0; LOout = 1'b1;
    #1 check("prio lo over pc", BusMuxOut, 32'h14);
    step();
    r_out_v[2] = 1'b1; r_in_v[2] = 1'b1; r_in_v[6] = 1'b1;
    step();
    read_reg(6, v);
    check("fanout r6", v, 32'h25);
    read_reg(2, v);
    check("self load r2", v, 32'h25);

    // Directed ALU cases with hand-computed results
    do_alu("mul", 13'd1 << 9, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    do_alu("div", 13'd1 << 10, 32'h25, 32'h14, 64'h0000_0011_0000_0001);
    do_alu("div0", 13'd1 << 10, 32'h25, 32'h0, 64'h0000_0025_0000_0000);
    do_alu("divneg", 13'd1 << 10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    do_alu("shra", 13'd1 << 3, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000);
    do_alu("shr", 13'd1 << 2, 32'h8000_0000, 32'd4, 64'h0000_0000_0800_0000);
    do_alu("rol", 13'd1 << 6, 32'h8000_0000, 32'd4, 64'h0000_0000_0000_0008);
    do_alu("ror", 13'd1 << 5, 32'h1, 32'd1, 64'h0000_0000_8000_0000);
    do_alu("shl", 13'd1 << 4, 32'h1, 32'h23, 64'h0000_0000_0000_0008);
    do_alu("neg", 13'd1 << 11, 32'h0, 32'hF, 64'h0000_0000_FFFF_FFF1);
    do_alu("not", 13'd1 << 12, 32'h0, 32'hF, 64'h0000_0000_FFFF_FFF0);
    do_alu("and", 13'd1 << 7, 32'h25, 32'h14, 64'h4);
    do_alu("or", 13'd1 << 8, 32'h25, 32'h14, 64'h35);
    do_alu("inc", 13'd0, 32'h25, 32'hFFFF_FFFF, 64'h0);
    do_alu("add+sub", 13'b11, 32'h25, 32'h14, 64'h39);
    do_alu("sub+mul", 13'b10_0000_0010, 32'h25, 32'h14, 64'h11);

    // Randomized ALU traffic against the reference model
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 13);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      m = (k == 13) ? 13'd0 : (13'd1 << k);
      do_alu($sformatf("rand%0d op%0d", i, k), m, a, b, ref_alu(k, a, b));
    end

    // Asynchronous reset between edges with loads pending
    load_mem(1, 32'h11);
    Zin = 1'b1;
    #2 Clear = 1'b0;
    #1 check("areset mar", MARq, 32'h0);
    check("areset ir", IRq, 32'h0);
    r_out_v[1] = 1'b1;
    #1 check("areset r1", BusMuxOut, 32'h0);
    r_out_v[1] = 1'b0;
    Read = 1'b1; MDRin = 1'b1; Mdatain = 32'hDEAD_BEEF; PCin = 1'b1; MARin = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Read = 1'b0; MDRin = 1'b0; Zin = 1'b0; PCin = 1'b0; MARin = 1'b0;
    MDRout = 1'b1;
    #1 check("held mdr", BusMuxOut, 32'h0);
    check("held mar", MARq, 32'h0);
    Clear = 1'b1;
    ctrl_clear();
    read_z(lo, hi);
    check("post reset zlow", lo, 32'h0);
    check("post reset zhigh", hi, 32'h0);
    PCout = 1'b1;
    #1 check("post reset pc", BusMuxOut, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_path.md
# data_path

32-bit bus-based CPU datapath: sixteen general-purpose registers, PC, IR, MAR, MDR, HI/LO, Y and a 64-bit Z register share one internal bus feeding a combinational ALU. All register transfers, ALU operation selects and memory-read capture are driven cycle by cycle by the external control unit. This block is the execution core under the processor's control sequencer.

## Interface
Parameters: none.

Ports:
- Clock  in  1  system clock; all registers update on its rising edge.
- Clear  in  1  reset, asynchronous, active-low; clears every register.
- HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin  in  1 each  register load enables.
- HIout, LOout, PCout, Zhighout, Zlowout, MDRout  in  1 each  bus drive selects.
- Read  in  1  MDR input mux select: 1 = Mdatain, 0 = bus.
- Mdatain  in  32  memory read data.
- R0out..R15out  in  1 each  drive general register Rn onto the bus.
- R0in..R15in  in  1 each  load general register Rn from the bus.
- ADD, SUB, SHR, SHRA, SHL, ROR, ROL, AND, OR, MUL, DIV, NEG, NOT  in  1 each  ALU operation selects, in this port order.
- BusMuxOut  out  32  current bus value.
- MARq  out  32  current MAR contents (memory address).

## Operation
- Bus: combinational mux. Priority when several selects are high: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR. No select high → bus = 0.
- Registers: R0–R15, HI, LO, PC, IR, Y, MAR load BusMuxOut when their enable is high. MDR loads (Read ? Mdatain : BusMuxOut) when MDRin is high. Z (64-bit: Zhigh/Zlow) loads the ALU result when Zin is high.
- ALU: A = Y, B = BusMuxOut. Result C is 64-bit; Zhigh = 0 unless stated.
  - ADD: A+B, mod 2^32.
  - SUB: A−B, mod 2^32.
  - AND / OR: bitwise.
  - SHR: A logical right shift by B[4:0].
  - SHRA: A arithmetic right shift by B[4:0].
  - SHL: A left shift by B[4:0].
  - ROR / ROL: A rotate by B[4:0].
  - MUL: signed A×B, 64-bit product in Zhigh:Zlow.
  - DIV: signed; Zlow = quotient A/B truncated toward zero, Zhigh = remainder (sign of A). B = 0 → Zlow = 0, Zhigh = A.
  - NEG: −B (unary, on the bus).
  - NOT: ~B (unary, on the bus).
  - No op select high → Zlow = B+1. This is the PC-increment path.
- Several op selects high: the first in port order wins.
- IR contents are held for the control unit; no decode in this block.

## Timing
- Reset: Clear low asynchronously forces every register, including MDR, Z, PC and IR, to 0. MARq reads 0. BusMuxOut is 0 while no out-select is high. Reset mid-operation aborts the transfer and wins over any load enable on the same edge.
- Bus and ALU are purely combinational, with zero-cycle latency.
- An out-select plus a matching in-enable held across one rising edge completes one register transfer per clock.
- ALU latency: Y loaded at edge n; op select and Zin at edge n+1 capture Z. Zlowout/Zhighout can drive the result during the following cycle.
- Memory read: Read and MDRin high at an edge capture Mdatain into MDR. The value is on the bus next cycle via MDRout.
- Fetch: T0 (PCout, MARin, Zin, no op) → MAR = PC, Z = PC+1. T1 (Zlowout, PCin, Read, MDRin) → PC = PC+1, MDR = Mdatain. T2 (MDRout, IRin) → IR = MDR.
- Simultaneous load of the same register from the bus is deterministic: it takes the current bus value.

## Test plan
- Register load/SUB: load R2 = 0x25, R3 = 0x14 via Mdatain/MDR. Then Y←R2, SUB with R3 and Zin, R1←Zlow → R1 = 0x00000011, Zhigh = 0.
- Fetch: PC = 0, Mdatain = 0x08860000, run T0–T2 → MAR = 0, PC = 1, IR = 0x08860000.
- MUL/DIV: Y = 0xFFFFFFFE, B = 3, MUL → Zhigh = 0xFFFFFFFF, Zlow = 0xFFFFFFFA. Y = 0x25, B = 0x14, DIV → Zlow = 1, Zhigh = 0x11. B = 0 → Zlow = 0, Zhigh = 0x25.
- Shifts/rotates: A = 0x80000000, B = 4.
  - SHRA → 0xF8000000.
  - SHR → 0x08000000.
  - ROL → 0x00000008.
  - A = 1, ROR by 1 → 0x80000000.
- Unary/logic: B = 0x0000000F → NEG 0xFFFFFFF1, NOT 0xFFFFFFF0. A = 0x25, B = 0x14 → AND 0x04, OR 0x35.
- Reset: with R1 = 0x11 and Zin active, pulse Clear low between edges → all registers read 0 immediately, and the next edge does not load while Clear is low.
